lpf_fir_sequencer: RTL and testbench
====================================

Name: lpf_fir_sequencer

Overview:
Sequences the 31-tap 320 Hz low-pass FIR. Stores incoming audio samples in a 32-entry circular buffer. On each sample strobe it walks the coefficient ROM index 0..30 over 31 cycles, multiply-accumulating buffered samples against ROM coefficients. It presents a filtered sample with a one-cycle valid pulse. Sits between the audio codec sample interface and downstream processing; the coefficient ROM is an external combinational block addressed by this module.

Parameters:
DATA_W, 8, signed sample width (x, y)
COEFF_W, 10, signed coefficient width
NTAPS, 31, number of taps; buffer depth is 2^IDX_W = 32
IDX_W, 5, coefficient index / buffer pointer width
ACC_W, 23, accumulator width, DATA_W+COEFF_W+IDX_W
SHIFT, 10, output arithmetic right shift; ROM DC gain is 1024

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
ready  in  1  one-cycle sample strobe; x is valid in the same cycle
x  in  DATA_W  signed input sample
coeff_index  out  IDX_W  address to coefficient ROM
coeff  in  COEFF_W  signed ROM data, combinational from coeff_index
y  out  DATA_W  signed filtered sample, acc >>> SHIFT, truncated
y_full  out  ACC_W  signed full-precision accumulator result
y_valid  out  1  one-cycle pulse when y and y_full update
busy  out  1  high while a MAC pass is in progress
overrun  out  1  sticky; set when ready arrives while busy

Behaviour:
- Single clock domain, named clock. Reset is synchronous, active-high, named reset. All state updates occur on the rising edge of clock.
- Reset (sync, active-high) clears:
  - all 32 buffer entries and the write pointer wptr to 0
  - acc, y and y_full to 0
  - y_valid, busy and overrun to 0
  - the FSM to IDLE
  - coeff_index to 0
- FSM states are IDLE, MAC and DONE.
- IDLE:
  - On ready: write x to buf[wptr], load rptr = wptr, load tap = 0, clear acc, then go to MAC. Call the ready edge cycle 0.
  - Otherwise stay in IDLE.
- MAC, cycles 1..NTAPS:
  - coeff_index = tap.
  - acc += sext(buf[rptr]) * coeff, a signed full-width product sign-extended to ACC_W.
  - rptr decrements modulo 32, wrapping 0 to 31. tap increments.
  - After tap NTAPS-1 (cycle 31), go to DONE.
- DONE, cycle 32:
  - y_full <= acc.
  - y <= acc[SHIFT+DATA_W-1:SHIFT], i.e. arithmetic shift then truncate. This is exact for ROM gain 1024 and in-range inputs.
  - y_valid = 1 for exactly this cycle.
  - wptr increments modulo 32. Go to IDLE.
- Latency: ready in cycle 0 produces y_valid in cycle 32. Minimum ready spacing is 33 cycles; the audio rate is far slower.
- Tap alignment: coeff index i multiplies sample x[n-i]. Index 0 is the newest sample. Buffer entry wptr-31 is unused.
- busy = 1 in MAC and DONE. coeff_index holds its last value when not in MAC.
- ready while busy is ignored: no buffer write and no pointer change. overrun is set and stays set until reset.
- ready in the same cycle as DONE is also ignored and sets overrun.
- Reset asserted mid-pass aborts the pass. No y_valid is produced, and all state returns to its reset values on that edge.
- The accumulator never overflows: 31 taps × 2^17 fits in 23 bits.
- y and y_full hold their value between updates.

Decomposition:
- Package lpf_pkg holds:
  - DATA_W, COEFF_W, IDX_W, NTAPS, ACC_W, SHIFT
  - the state enum {IDLE, MAC, DONE}
  - typedefs sample_t, coeff_t and acc_t
- One sub-module, lpf_sample_ring: 32×DATA_W register file with sync reset clear, a write port (we, waddr, wdata) and a combinational read port (raddr, rdata).
- FSM, counters and MAC stay in the top level. The coefficient ROM stays external.

Test Plan:
- Impulse: after reset, ready with x=127, then ready with x=0 for 40 samples → y_full sequence 508, 635, 889, 1270, 1778, …, 8128 (taps 14–16), …, 508, then 0 from the 32nd output on.
- DC positive: 40 samples x=100 → output 31 onward y_full=102400, y=100. Outputs 1..30 rise monotonically.
- DC negative: 40 samples x=-128 → output 31 onward y_full=-131072, y=-128. Verifies sign extension and shift.
- Timing: single ready at cycle 0 → busy high in cycles 1–32, y_valid only in cycle 32, coeff_index stepping 0..30 in cycles 1–31.
- Overrun: ready at cycle 0 and again at cycle 10 → second sample not stored, overrun=1 from cycle 11. A result appears at cycle 32. overrun remains 1 until reset.
- Reset mid-pass: reset at cycle 15 → no y_valid. Then buffer, y, busy and overrun read 0. The next impulse test reproduces the impulse sequence exactly.

Source files
------------

// File: rtl/lpf_pkg.sv
// ============================================================================
// Module : lpf_pkg
// Brief  : Shared widths, types and FSM states for the 31-tap low-pass FIR.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package lpf_pkg;

    localparam int DATA_W  = 8;
    localparam int COEFF_W = 10;
    localparam int IDX_W   = 5;
    localparam int NTAPS   = 31;
    localparam int ACC_W   = DATA_W + COEFF_W + IDX_W;
    localparam int SHIFT   = 10;

    typedef logic signed [DATA_W-1:0]  sample_t;
    typedef logic signed [COEFF_W-1:0] coeff_t;
    typedef logic signed [ACC_W-1:0]   acc_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/lpf_sample_ring.sv
// ============================================================================
// Module : lpf_sample_ring
// Brief  : 32-entry sample register file, one write port, async read port.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module lpf_sample_ring
    import lpf_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  sample_t          wdata,
    input  logic [IDX_W-1:0] raddr,
    output sample_t          rdata
);

    localparam int DEPTH = 1 << IDX_W;

    sample_t r_mem [0:DEPTH-1];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/lpf_fir_sequencer.sv
// ============================================================================
// Module : lpf_fir_sequencer
// Brief  : Buffers samples and runs one serial 31-tap MAC pass per strobe.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module lpf_fir_sequencer
    import lpf_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             ready,
    input  sample_t          x,
    output logic [IDX_W-1:0] coeff_index,
    input  coeff_t           coeff,
    output sample_t          y,
    output acc_t             y_full,
    output logic             y_valid,
    output logic             busy,
    output logic             overrun
);

    state_t                   r_state;
    logic [IDX_W-1:0]         r_wptr;
    logic [IDX_W-1:0]         r_rptr;
    logic [IDX_W-1:0]         r_tap;
    acc_t                     r_acc;
    sample_t                  r_y;
    acc_t                     r_y_full;
    logic                     r_y_valid;
    logic                     r_busy;
    logic                     r_overrun;

    logic                     w_we;
    sample_t                  w_sample;
    logic signed [DATA_W+COEFF_W-1:0] w_prod;
    acc_t                     w_acc_next;
    logic                     w_last;

    // Strobes are only accepted when idle; anything else is an overrun.
    assign w_we = (r_state == IDLE) && ready;

    lpf_sample_ring u_ring (
        .clock (clock),
        .reset (reset),
        .we    (w_we),
        .waddr (r_wptr),
        .wdata (x),
        .raddr (r_rptr),
        .rdata (w_sample)
    );

    assign w_prod     = w_sample * coeff;
    assign w_acc_next = r_acc + acc_t'(w_prod);
    assign w_last     = (r_tap == IDX_W'(NTAPS - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= IDLE;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_tap     <= '0;
            r_acc     <= '0;
            r_y       <= '0;
            r_y_full  <= '0;
            r_y_valid <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_y_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (ready) begin
                        r_rptr  <= r_wptr;
                        r_tap   <= '0;
                        r_acc   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= MAC;
                    end
                end
                MAC: begin
                    r_acc  <= w_acc_next;
                    r_rptr <= r_rptr - IDX_W'(1);
                    // Results are published on the way into DONE so the
                    // valid pulse and the data share the DONE cycle.
                    if (w_last) begin
                        r_y_full  <= w_acc_next;
                        r_y       <= w_acc_next[SHIFT+DATA_W-1:SHIFT];
                        r_y_valid <= 1'b1;
                        r_state   <= DONE;
                    end else begin
                        r_tap <= r_tap + IDX_W'(1);
                    end
                end
                DONE: begin
                    r_wptr  <= r_wptr + IDX_W'(1);
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
            if (ready && (r_state != IDLE)) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign coeff_index = r_tap;
    assign y           = r_y;
    assign y_full      = r_y_full;
    assign y_valid     = r_y_valid;
    assign busy        = r_busy;
    assign overrun     = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_lpf_fir_sequencer.sv
// ============================================================================
// Module : tb_lpf_fir_sequencer
// Brief  : Directed table-driven bench for lpf_fir_sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_lpf_fir_sequencer;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              ready = 1'b0;
    logic signed [7:0] x     = '0;
    logic [4:0]        coeff_index;
    logic signed [9:0] coeff;
    logic signed [7:0] y;
    logic signed [22:0] y_full;
    logic              y_valid;
    logic              busy;
    logic              overrun;

    int checks   = 0;
    int failures = 0;

    // Symmetric low-pass coefficients, DC gain 1024.
    int h [0:30] = '{4, 5, 7, 10, 14, 19, 25, 31, 37, 43, 48, 53, 58, 62, 64,
                     64, 64, 62, 58, 53, 48, 43, 37, 31, 25, 19, 14, 10, 7, 5, 4};

    typedef struct {
        int x;
        int exp_full;
        int exp_y;
    } vec_t;

    vec_t vecs [0:40];
    int   nvec;

    always #5 clock = ~clock;

    always_comb begin
        coeff = '0;
        if (coeff_index < 5'd31) coeff = 10'(h[coeff_index]);
    end

    lpf_fir_sequencer dut (
        .clock       (clock),
        .reset       (reset),
        .ready       (ready),
        .x           (x),
        .coeff_index (coeff_index),
        .coeff       (coeff),
        .y           (y),
        .y_full      (y_full),
        .y_valid     (y_valid),
        .busy        (busy),
        .overrun     (overrun)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ready = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    // Fill expected outputs by direct convolution of the table inputs
    // (buffer starts all-zero).
    task automatic fill_expected();
        for (int n = 0; n < nvec; n++) begin
            int acc;
            int t;
            logic signed [7:0] b;
            acc = 0;
            for (int i = 0; i < 31; i++) begin
                if (n - i >= 0) acc += vecs[n-i].x * h[i];
            end
            t = acc >>> 10;
            b = t[7:0];
            vecs[n].exp_full = acc;
            vecs[n].exp_y    = b;
        end
    endtask

    task automatic send(input int sx, output int gf, output int gy);
        ready = 1'b1;
        x     = 8'(sx);
        step();
        ready = 1'b0;
        x     = '0;
        for (int k = 0; k < 40 && !y_valid; k++) step();
        chk("y_valid_seen", int'(y_valid), 1);
        gf = y_full;
        gy = y;
        step();
    endtask

    task automatic run_table(input string name);
        int gf;
        int gy;
        for (int n = 0; n < nvec; n++) begin
            send(vecs[n].x, gf, gy);
            chk({name, "_y_full"}, gf, vecs[n].exp_full);
            chk({name, "_y"}, gy, vecs[n].exp_y);
        end
    endtask

    initial begin
        int gf;
        int gy;
        int seen;

        do_reset();
        chk("rst_y", int'(y), 0);
        chk("rst_y_full", int'(y_full), 0);
        chk("rst_y_valid", int'(y_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_coeff_index", int'(coeff_index), 0);

        // Timing: single strobe at cycle 0
        ready = 1'b1;
        x     = '0;
        step();
        ready = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            chk("tim_busy", int'(busy), (k <= 32) ? 1 : 0);
            chk("tim_y_valid", int'(y_valid), (k == 32) ? 1 : 0);
            if (k <= 31) chk("tim_coeff_index", int'(coeff_index), k - 1);
            step();
        end

        // Overrun: second strobe at cycle 10 must be dropped
        chk("ovr_before", int'(overrun), 0);
        ready = 1'b1;
        x     = 8'sd55;
        step();
        ready = 1'b0;
        for (int k = 1; k < 10; k++) step();
        ready = 1'b1;
        x     = 8'sd99;
        step();
        ready = 1'b0;
        x     = '0;
        chk("ovr_set", int'(overrun), 1);
        chk("ovr_busy", int'(busy), 1);
        seen = 0;
        for (int k = 11; k <= 40; k++) begin
            if (y_valid) begin
                chk("ovr_valid_cycle", k, 32);
                chk("ovr_y_full", int'(y_full), 55 * 4);
                seen++;
            end
            step();
        end
        chk("ovr_one_result", seen, 1);
        send(0, gf, gy);
        chk("ovr_next_y_full", gf, 55 * 5);
        chk("ovr_sticky", int'(overrun), 1);

        // Reset at cycle 15 of a pass
        ready = 1'b1;
        x     = 8'sd100;
        step();
        ready = 1'b0;
        for (int k = 1; k < 15; k++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_busy", int'(busy), 0);
        chk("mid_overrun", int'(overrun), 0);
        chk("mid_y", int'(y), 0);
        chk("mid_y_full", int'(y_full), 0);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (y_valid) seen++;
            step();
        end
        chk("mid_no_valid", seen, 0);

        // Impulse, without a further reset: relies on the buffer clear
        nvec = 41;
        vecs[0].x = 127;
        for (int n = 1; n < nvec; n++) vecs[n].x = 0;
        fill_expected();
        run_table("imp");

        // DC positive
        do_reset();
        nvec = 40;
        for (int n = 0; n < nvec; n++) vecs[n].x = 100;
        fill_expected();
        run_table("dcp");
        chk("dcp_final_full", int'(y_full), 102400);
        chk("dcp_final_y", int'(y), 100);

        // DC negative
        do_reset();
        nvec = 40;
        for (int n = 0; n < nvec; n++) vecs[n].x = -128;
        fill_expected();
        run_table("dcn");
        chk("dcn_final_full", int'(y_full), -131072);
        chk("dcn_final_y", int'(y), -128);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
